// File: rtl/response_checker.sv
// Clocked response checker: compares a stream of valid observations against a
// parameterised expected-response table and reports per-sample and run verdicts.
module response_checker #(
  parameter int                         WIDTH    = 1,
  parameter int                         DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0]     EXPECTED = 4'b0111,
  localparam int                        CW       = $clog2(DEPTH + 1),
  localparam int                        IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CW-1:0]    err_count,
  output logic             first_fail_valid,
  output logic [IW-1:0]    first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CW-1:0] ERR_MAX  = CW'(DEPTH);

  state_t           state, state_next;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] exp_tbl [2**IW];
  logic [WIDTH-1:0] exp_entry;
  logic             sample, start_run, is_last, miss;

  // Table padded to a power of two so idx can address it at its natural width.
  for (genvar i = 0; i < 2**IW; i++) begin : g_tbl
    if (i < DEPTH) begin : g_used
      assign exp_tbl[i] = EXPECTED[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign exp_tbl[i] = '0;
    end
  end

  assign exp_entry = exp_tbl[idx];
  assign sample    = (state == S_CHECK) && obs_valid;
  assign start_run = start && (state != S_CHECK);
  assign is_last   = (idx == LAST_IDX);
  // Case-inequality so an X/Z observation is flagged rather than silently passed.
  assign miss      = (obs !== exp_entry);

  assign busy = (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:  if (start)                state_next = S_CHECK;
      S_CHECK: if (obs_valid && is_last) state_next = S_DONE;
      S_DONE:  if (start)                state_next = S_CHECK;
      default:                           state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      mismatch         <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      mismatch <= 1'b0;
      if (start_run) begin
        idx              <= '0;
        err_count        <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
      end else if (sample) begin
        if (!is_last) idx <= idx + 1'b1;
        if (miss) begin
          mismatch <= 1'b1;
          if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= idx;
          end
        end
      end
    end
  end

endmodule

// File: doc/response_checker.md
Name: response_checker

Overview:
- Synthesizable, clocked consumer for vector-driven unit tests: the receiving end of the stimulus-vector scheme our `*_sim` benches use.
- Holds a parameterised expected-response table and compares the DUT output against entry N on the Nth valid sample.
- Reports a per-sample mismatch pulse, a saturating error count, the first failing index, and a final done/pass verdict.
- Instantiated beside the DUT in a sim top; the sim top ends the run when `done` rises.

Parameters:
- WIDTH, 1: width of one observed sample / expected entry.
- DEPTH, 4: number of expected entries; legal range 1..256.
- EXPECTED, 4'b0111: packed table, DEPTH*WIDTH bits. Entry i occupies bits [i*WIDTH +: WIDTH]. The default is the NAND truth table for a={0,1,0,1}, b={0,0,1,1}, i.e. entries 1,1,1,0.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin or restart a check run; sampled on clk.
- obs_valid  in  1  obs is a sample to be checked this cycle.
- obs  in  WIDTH  observed DUT output.
- busy  out  1  run in progress (CHECK state).
- done  out  1  run complete; held until the next start.
- pass  out  1  valid only when done=1; 1 iff err_count==0.
- mismatch  out  1  one-cycle pulse, registered, for a failing sample.
- err_count  out  $clog2(DEPTH+1)  mismatches this run; saturates at DEPTH.
- first_fail_valid  out  1  at least one mismatch has been recorded this run.
- first_fail_idx  out  max(1,$clog2(DEPTH))  index of the first mismatching entry.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state=IDLE, idx=0.
  - busy, done, pass, mismatch, first_fail_valid = 0.
  - err_count=0, first_fail_idx=0.
  - Reset mid-run aborts immediately with no verdict.
- State IDLE:
  - obs_valid is ignored.
  - start=1 → CHECK next cycle; clears idx, err_count, first_fail_* and mismatch.
- State CHECK (busy=1):
  - On each obs_valid=1 cycle, compare obs with EXPECTED[idx*WIDTH +: WIDTH] using case-inequality, so X or Z on obs counts as a mismatch in simulation.
  - On a mismatch, the following cycle shows:
    - mismatch=1;
    - err_count+1, saturating;
    - if first_fail_valid was 0: first_fail_idx=idx and first_fail_valid=1.
  - idx increments by 1 per valid sample; it never wraps inside a run.
  - A valid sample at idx==DEPTH-1 → DONE next cycle, with busy=0, done=1, pass=(final err_count==0).
  - The comparison of this last sample is included in err_count and pass in that same cycle.
  - obs_valid=0 cycles: no compare, idx holds, mismatch=0.
  - start during CHECK is ignored; the run is not restarted.
- State DONE:
  - done and pass held; obs_valid ignored; idx frozen at DEPTH-1.
  - start=1 → CHECK next cycle with counters cleared, done=0 and pass=0 that cycle.
- Latency:
  - Sample at cycle t is reflected in mismatch, err_count and first_fail_* at t+1.
  - done rises at t+1 after the last sample.
- Degenerate case: with DEPTH=1, the first valid sample completes the run.
- Simultaneous start and obs_valid:
  - In IDLE or DONE, start wins and the sample is discarded.
  - In CHECK, the sample is checked and start is ignored.

Test Plan:
1. Defaults; reset, start, then obs=1,1,1,0 with obs_valid every cycle → mismatch never pulses, err_count=0, done=1 one cycle after the 4th sample, pass=1, first_fail_valid=0.
2. Defaults; obs=1,0,1,1 → mismatch pulses after samples 1 and 3, err_count=2, first_fail_idx=1, first_fail_valid=1, pass=0.
3. Gapped valid: obs_valid=1,0,0,1,1,0,1 carrying correct data → idx advances only on valid cycles, done after the 4th valid sample, pass=1. Drive obs=X on the invalid cycles → no mismatch.
4. Start in CHECK after 2 samples → ignored; run completes on 2 further samples. Then start in DONE → done=0, err_count=0; a second run with all-wrong data gives err_count=4 (saturated), first_fail_idx=0.
5. Assert rst_n=0 asynchronously after 2 samples (one of them bad) → all outputs 0 without waiting for a clk edge. The next start gives a clean run.
6. WIDTH=2, DEPTH=3, EXPECTED=6'b10_01_11; obs=3,1,0 → err_count=1, first_fail_idx=2, pass=0. Also obs=2'bx0 on entry 0 → counted as a mismatch.
